pipeline_debug_controller: RTL and testbench

- Parametrised successor to the single-step UART debug path in the pipeline top.
- Consumes command bytes from a UART RX FIFO and gates the pipeline via a clock-enable.
- Supports continuous run, single step, N-step and a PC breakpoint.
- On every halt, streams a framed snapshot of an arbitrary-width debug vector to the UART TX FIFO.

---
 rtl/pipeline_debug_controller.sv | 208 ++++++++++++++++++++
 tb/tb_pipeline_debug_controller.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_debug_controller.sv
// Pipeline debug controller: decodes UART command bytes to run, single-step,
// N-step or break on a PC. It gates the pipeline clock-enable, and on every
// halt it streams a framed snapshot of the debug vector: header, data bytes,
// then an XOR checksum.
module pipeline_debug_controller #(
    parameter int unsigned NUM_WORDS  = 8,
    parameter int unsigned WORD_WIDTH = 32,
    parameter int unsigned PC_WIDTH   = 11,
    parameter bit          MSB_FIRST  = 1'b0
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [7:0]                      rx_data,
    input  logic                            rx_empty,
    output logic                            rd_uart,
    output logic [7:0]                      tx_data,
    input  logic                            tx_full,
    output logic                            wr_uart,
    input  logic [NUM_WORDS*WORD_WIDTH-1:0] debug_vector,
    input  logic [PC_WIDTH-1:0]             pc,
    output logic                            pipe_enable,
    output logic                            halted,
    output logic                            busy
);

    localparam int unsigned VecWidth     = NUM_WORDS * WORD_WIDTH;
    localparam int unsigned BytesPerWord = WORD_WIDTH / 8;
    localparam int unsigned NumBytes     = VecWidth / 8;
    localparam int unsigned FrameLen     = NumBytes + 2;
    localparam int unsigned IdxW         = $clog2(FrameLen);
    localparam int unsigned SelW         = (NumBytes > 1) ? $clog2(NumBytes) : 1;
    localparam int unsigned BpArgBytes   = (PC_WIDTH + 7) / 8;
    localparam int unsigned ArgW         = 8 * BpArgBytes;

    localparam logic [IdxW-1:0] IdxLast   = IdxW'(FrameLen - 1);
    localparam logic            BpArgLast = 1'(BpArgBytes - 1);

    localparam logic [7:0] CmdRun   = 8'h63;
    localparam logic [7:0] CmdStep  = 8'h73;
    localparam logic [7:0] CmdNStep = 8'h6E;
    localparam logic [7:0] CmdBreak = 8'h62;
    localparam logic [7:0] CmdClear = 8'h78;
    localparam logic [7:0] CmdDump  = 8'h64;
    localparam logic [7:0] CmdHalt  = 8'h68;
    localparam logic [7:0] FrameHdr = 8'hA5;

    typedef enum logic [2:0] {StIdle, StReadArg, StStep, StRun, StDump} state_e;

    state_e              state_q;
    logic                arg_is_bp_q;
    logic                arg_cnt_q;
    logic [ArgW-1:0]     arg_val_q;
    logic [PC_WIDTH-1:0] bp_q;
    logic                bp_valid_q;
    logic [7:0]          count_q;
    logic                run_first_q;
    logic                dump_entry_q;
    logic [IdxW-1:0]     idx_q;
    logic [7:0]          csum_q;
    logic [VecWidth-1:0] shadow_q;

    logic            rx_pop;
    logic            bp_hit;
    logic            halt_req;
    logic            arg_last;
    logic [ArgW-1:0] arg_next;
    logic            enter_dump;
    logic [SelW-1:0] data_sel;
    logic [7:0]      frame_byte;
    logic [7:0]      data_bytes [NumBytes];

    // Pop only in states that accept commands; reset suppresses every strobe.
    assign rx_pop = !reset && !rx_empty && (state_q inside {StIdle, StReadArg, StRun});

    // The first RUN cycle skips the compare so 'c' while parked on bp makes progress.
    assign bp_hit   = bp_valid_q && (pc == bp_q) && !run_first_q;
    assign halt_req = (state_q == StRun) && rx_pop && (rx_data == CmdHalt);

    assign arg_last = arg_is_bp_q ? (arg_cnt_q == BpArgLast) : 1'b1;
    assign arg_next = arg_val_q | (ArgW'(rx_data) << {arg_cnt_q, 3'b000});

    // Byte lanes of the snapshot in transmit order: word 0 first.
    for (genvar w = 0; w < NUM_WORDS; w++) begin : g_word
        for (genvar j = 0; j < BytesPerWord; j++) begin : g_byte
            localparam int unsigned Lane = MSB_FIRST ? (BytesPerWord - 1 - j) : j;
            assign data_bytes[w*BytesPerWord + j] = shadow_q[w*WORD_WIDTH + Lane*8 +: 8];
        end
    end

    // Select the frame byte for the current index: header, data or checksum.
    always_comb begin
        data_sel = SelW'(idx_q - IdxW'(1));
        if (idx_q == '0) begin
            frame_byte = FrameHdr;
        end else if (idx_q == IdxLast) begin
            frame_byte = csum_q;
        end else begin
            frame_byte = data_bytes[data_sel];
        end
    end

    // Decide whether this cycle hands over to the snapshot frame.
    always_comb begin
        enter_dump = 1'b0;
        unique case (state_q)
            StIdle:    enter_dump = rx_pop && (rx_data == CmdDump);
            StReadArg: enter_dump = rx_pop && arg_last && !arg_is_bp_q && (rx_data == 8'h00);
            StStep:    enter_dump = (count_q == 8'd1);
            StRun:     enter_dump = bp_hit || halt_req;
            default:   enter_dump = 1'b0;
        endcase
    end

    assign rd_uart     = rx_pop;
    assign wr_uart     = !reset && (state_q == StDump) && !tx_full;
    assign tx_data     = wr_uart ? frame_byte : 8'h00;
    assign pipe_enable = !reset && ((state_q == StStep) ||
                                    ((state_q == StRun) && !bp_hit && !halt_req));
    assign halted      = reset || (state_q == StIdle) || (state_q == StReadArg);
    assign busy        = !reset && (state_q == StDump);

    // Control FSM: command decode, argument collection, step count, frame sequencing.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= StIdle;
            arg_is_bp_q  <= 1'b0;
            arg_cnt_q    <= 1'b0;
            arg_val_q    <= '0;
            bp_q         <= '0;
            bp_valid_q   <= 1'b0;
            count_q      <= '0;
            run_first_q  <= 1'b0;
            dump_entry_q <= 1'b0;
            idx_q        <= '0;
            csum_q       <= '0;
        end else begin
            dump_entry_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (rx_pop) begin
                        case (rx_data)
                            CmdRun: begin
                                state_q     <= StRun;
                                run_first_q <= 1'b1;
                            end
                            CmdStep: begin
                                count_q <= 8'd1;
                                state_q <= StStep;
                            end
                            CmdNStep, CmdBreak: begin
                                arg_is_bp_q <= (rx_data == CmdBreak);
                                arg_cnt_q   <= 1'b0;
                                arg_val_q   <= '0;
                                state_q     <= StReadArg;
                            end
                            CmdClear: bp_valid_q <= 1'b0;
                            default: ;  // 'd' handled by enter_dump, others dropped
                        endcase
                    end
                end
                StReadArg: begin
                    if (rx_pop) begin
                        arg_val_q <= arg_next;
                        arg_cnt_q <= arg_cnt_q + 1'b1;
                        if (arg_last) begin
                            if (arg_is_bp_q) begin
                                bp_q       <= PC_WIDTH'(arg_next);
                                bp_valid_q <= 1'b1;
                                state_q    <= StIdle;
                            end else if (rx_data != 8'h00) begin
                                count_q <= rx_data;
                                state_q <= StStep;
                            end
                        end
                    end
                end
                StStep: count_q <= count_q - 8'd1;
                StRun:  run_first_q <= 1'b0;
                StDump: begin
                    if (wr_uart) begin
                        idx_q <= idx_q + IdxW'(1);
                        if ((idx_q != '0) && (idx_q != IdxLast)) begin
                            csum_q <= csum_q ^ frame_byte;
                        end
                        if (idx_q == IdxLast) begin
                            state_q <= StIdle;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
            if (enter_dump) begin
                state_q      <= StDump;
                idx_q        <= '0;
                csum_q       <= '0;
                dump_entry_q <= 1'b1;
            end
        end
    end

    // Freeze the debug vector on the first DUMP cycle; the header goes out meanwhile.
    always_ff @(posedge clock) begin
        if (dump_entry_q) begin
            shadow_q <= debug_vector;
        end
    end

endmodule

// File: tb/tb_pipeline_debug_controller.sv
// Bench for pipeline_debug_controller: two instances (LSB-first and MSB-first)
// share one RX byte queue. A transaction-level model predicts every output on
// each falling edge. Literal frames and enable counts pin the model.
module tb_pipeline_debug_controller;

    localparam int NW = 2;
    localparam int WW = 32;
    localparam int PW = 11;

    localparam int M_IDLE = 0;
    localparam int M_ARG  = 1;
    localparam int M_STEP = 2;
    localparam int M_RUN  = 3;
    localparam int M_DUMP = 4;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic [7:0]       rx_data = 8'h00;
    logic             rx_empty = 1'b1;
    logic             tx_full = 1'b0;
    logic [NW*WW-1:0] debug_vector = {32'h11223344, 32'hAABBCCDD};
    logic [PW-1:0]    pc = '0;

    logic       rd0, wr0, pe0, halt0, busy0;
    logic       rd1, wr1, pe1, halt1, busy1;
    logic [7:0] tx0, tx1;

    pipeline_debug_controller #(
        .NUM_WORDS(NW), .WORD_WIDTH(WW), .PC_WIDTH(PW), .MSB_FIRST(1'b0)
    ) dut_lsb (
        .clock(clock), .reset(reset), .rx_data(rx_data), .rx_empty(rx_empty),
        .rd_uart(rd0), .tx_data(tx0), .tx_full(tx_full), .wr_uart(wr0),
        .debug_vector(debug_vector), .pc(pc), .pipe_enable(pe0), .halted(halt0),
        .busy(busy0)
    );

    pipeline_debug_controller #(
        .NUM_WORDS(NW), .WORD_WIDTH(WW), .PC_WIDTH(PW), .MSB_FIRST(1'b1)
    ) dut_msb (
        .clock(clock), .reset(reset), .rx_data(rx_data), .rx_empty(rx_empty),
        .rd_uart(rd1), .tx_data(tx1), .tx_full(tx_full), .wr_uart(wr1),
        .debug_vector(debug_vector), .pc(pc), .pipe_enable(pe1), .halted(halt1),
        .busy(busy1)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] rxq [$];
    logic [7:0] log0 [$];
    logic [7:0] log1 [$];
    int pe_count = 0;
    int wr_count = 0;
    logic pop_pending = 1'b0;
    logic pe_prev = 1'b0;

    // Hand-computed frames for {32'h11223344, 32'hAABBCCDD}; checksum = 0x44.
    logic [7:0] exp_lsb [10] = '{8'hA5, 8'hDD, 8'hCC, 8'hBB, 8'hAA,
                                 8'h44, 8'h33, 8'h22, 8'h11, 8'h44};
    logic [7:0] exp_msb [10] = '{8'hA5, 8'hAA, 8'hBB, 8'hCC, 8'hDD,
                                 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};

    // Model state
    int         m_mode = M_IDLE;
    int         m_need, m_got, m_arg, m_left, m_bp;
    logic       m_isbp = 1'b0;
    logic       m_bpv = 1'b0;
    logic       m_grace = 1'b0;
    logic [7:0] fq0 [$];
    logic [7:0] fq1 [$];
    logic       e_rd, e_wr, e_pe, e_halt, e_busy, avail, stop;
    logic [7:0] e_tx0, e_tx1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic build_frames();
        logic [WW-1:0] w;
        logic [7:0]    c;
        c = 8'h00;
        fq0.delete();
        fq1.delete();
        fq0.push_back(8'hA5);
        fq1.push_back(8'hA5);
        for (int k = 0; k < NW; k++) begin
            w = debug_vector[k*WW +: WW];
            for (int j = 0; j < WW/8; j++) begin
                fq0.push_back(w[8*j +: 8]);
                fq1.push_back(w[WW-8-8*j +: 8]);
                c = c ^ w[8*j +: 8];
            end
        end
        fq0.push_back(c);
        fq1.push_back(c);
    endtask

    // Predict this cycle's outputs from the model, compare, then advance the model.
    always @(negedge clock) begin
        e_rd = 1'b0; e_wr = 1'b0; e_pe = 1'b0; e_busy = 1'b0; e_halt = 1'b1;
        e_tx0 = 8'h00; e_tx1 = 8'h00;
        if (reset) begin
            m_mode = M_IDLE; m_bpv = 1'b0; m_grace = 1'b0;
            fq0.delete(); fq1.delete();
        end else begin
            avail  = (m_mode == M_IDLE || m_mode == M_ARG || m_mode == M_RUN) && !rx_empty;
            e_rd   = avail;
            e_halt = (m_mode == M_IDLE || m_mode == M_ARG);
            e_busy = (m_mode == M_DUMP);
            case (m_mode)
                M_IDLE: if (avail) begin
                    case (rx_data)
                        8'h63: begin m_mode = M_RUN; m_grace = 1'b1; end
                        8'h73: begin m_left = 1; m_mode = M_STEP; end
                        8'h6E: begin m_need = 1; m_isbp = 1'b0; m_got = 0; m_arg = 0; m_mode = M_ARG; end
                        8'h62: begin m_need = (PW+7)/8; m_isbp = 1'b1; m_got = 0; m_arg = 0; m_mode = M_ARG; end
                        8'h78: m_bpv = 1'b0;
                        8'h64: m_mode = M_DUMP;
                        default: ;
                    endcase
                end
                M_ARG: if (avail) begin
                    m_arg = m_arg + (int'(rx_data) << (8*m_got));
                    m_got++;
                    if (m_got == m_need) begin
                        if (m_isbp) begin
                            m_bp = m_arg % (1 << PW); m_bpv = 1'b1; m_mode = M_IDLE;
                        end else if (m_arg == 0) begin
                            m_mode = M_DUMP;
                        end else begin
                            m_left = m_arg; m_mode = M_STEP;
                        end
                    end
                end
                M_STEP: begin
                    e_pe = 1'b1;
                    m_left--;
                    if (m_left == 0) m_mode = M_DUMP;
                end
                M_RUN: begin
                    stop = (m_bpv && !m_grace && int'(pc) == m_bp) ||
                           (avail && rx_data == 8'h68);
                    e_pe = !stop;
                    m_grace = 1'b0;
                    if (stop) m_mode = M_DUMP;
                end
                M_DUMP: begin
                    if (fq0.size() == 0) build_frames();
                    if (!tx_full) begin
                        e_wr  = 1'b1;
                        e_tx0 = fq0.pop_front();
                        e_tx1 = fq1.pop_front();
                        if (fq0.size() == 0) m_mode = M_IDLE;
                    end
                end
                default: m_mode = M_IDLE;
            endcase
        end
        chk("rd_uart_lsb", 32'(rd0), 32'(e_rd));
        chk("rd_uart_msb", 32'(rd1), 32'(e_rd));
        chk("wr_uart_lsb", 32'(wr0), 32'(e_wr));
        chk("wr_uart_msb", 32'(wr1), 32'(e_wr));
        chk("pipe_enable_lsb", 32'(pe0), 32'(e_pe));
        chk("pipe_enable_msb", 32'(pe1), 32'(e_pe));
        chk("halted_lsb", 32'(halt0), 32'(e_halt));
        chk("halted_msb", 32'(halt1), 32'(e_halt));
        chk("busy_lsb", 32'(busy0), 32'(e_busy));
        chk("busy_msb", 32'(busy1), 32'(e_busy));
        if (e_wr) begin
            chk("tx_data_lsb", 32'(tx0), 32'(e_tx0));
            chk("tx_data_msb", 32'(tx1), 32'(e_tx1));
        end
        if (wr0) log0.push_back(tx0);
        if (wr1) log1.push_back(tx1);
        if (pe0) pe_count++;
        if (wr0) wr_count++;
        pop_pending = e_rd;
        pe_prev     = e_pe && !reset;
    end

    task automatic refresh_rx();
        rx_empty = (rxq.size() == 0);
        rx_data  = rx_empty ? 8'h00 : rxq[0];
    endtask

    // Advance one clock; the RX queue pops and pc advances like a live pipeline.
    task automatic tick();
        @(posedge clock);
        #1;
        if (pop_pending && rxq.size() > 0) void'(rxq.pop_front());
        if (pe_prev) pc = pc + 1'b1;
        refresh_rx();
    endtask

    task automatic send(input logic [7:0] b);
        rxq.push_back(b);
        refresh_rx();
    endtask

    task automatic clear_logs();
        log0.delete();
        log1.delete();
        pe_count = 0;
        wr_count = 0;
    endtask

    task automatic run_until_halted(input string name);
        int n = 0;
        while (!(rxq.size() == 0 && halt0 && !busy0) && n < 600) begin
            tick();
            n++;
        end
        chk({name, "_halt_in_budget"}, 32'(n < 600), 32'd1);
    endtask

    task automatic wait_log(input int count, input string name);
        int n = 0;
        while (log0.size() < count && n < 200) begin
            tick();
            n++;
        end
        chk({name, "_bytes_in_budget"}, 32'(n < 200), 32'd1);
    endtask

    task automatic check_frames(input string name);
        chk({name, "_len_lsb"}, 32'(log0.size()), 32'd10);
        chk({name, "_len_msb"}, 32'(log1.size()), 32'd10);
        for (int i = 0; i < 10; i++) begin
            if (i < log0.size()) chk({name, "_byte_lsb"}, 32'(log0[i]), 32'(exp_lsb[i]));
            if (i < log1.size()) chk({name, "_byte_msb"}, 32'(log1[i]), 32'(exp_msb[i]));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        int wr_before;
        repeat (3) tick();
        reset = 1'b0;
        chk("reset_halted", 32'(halt0), 32'd1);
        chk("reset_pipe_enable", 32'(pe0), 32'd0);
        chk("reset_busy", 32'(busy0), 32'd0);

        // Single step
        clear_logs();
        send(8'h73);
        run_until_halted("step");
        chk("step_enable_cycles", 32'(pe_count), 32'd1);
        check_frames("step_frame");

        // N-step of 5, then N-step of 0
        clear_logs();
        send(8'h6E); send(8'h05);
        run_until_halted("nstep5");
        chk("nstep5_enable_cycles", 32'(pe_count), 32'd5);
        check_frames("nstep5_frame");
        clear_logs();
        send(8'h6E); send(8'h00);
        run_until_halted("nstep0");
        chk("nstep0_enable_cycles", 32'(pe_count), 32'd0);
        chk("nstep0_frame_len", 32'(log0.size()), 32'd10);

        // Breakpoint at 0x012, run from 0x010
        send(8'h62); send(8'h12); send(8'h00);
        run_until_halted("bp_load");
        pc = 11'h010;
        clear_logs();
        send(8'h63);
        run_until_halted("bp_run");
        chk("bp_stop_pc", 32'(pc), 32'h012);
        chk("bp_enable_cycles", 32'(pe_count), 32'd2);
        chk("bp_frame_len", 32'(log0.size()), 32'd10);

        // 'c' while parked on the breakpoint moves on, then halt with 'h'
        clear_logs();
        send(8'h63);
        repeat (6) tick();
        send(8'h68);
        run_until_halted("parked_run");
        chk("parked_enable_cycles", 32'(pe_count), 32'd5);
        chk("parked_pc", 32'(pc), 32'h017);

        // Clear breakpoint, run 20 cycles past it, halt
        send(8'h78);
        run_until_halted("bp_clear");
        pc = 11'h010;
        clear_logs();
        send(8'h63);
        repeat (21) tick();
        send(8'h68);
        run_until_halted("halt_run");
        chk("halt_enable_cycles", 32'(pe_count), 32'd20);
        chk("halt_pc", 32'(pc), 32'h024);
        check_frames("halt_frame");

        // TX backpressure for 7 cycles after byte 3
        clear_logs();
        send(8'h64);
        wait_log(3, "stall");
        tx_full = 1'b1;
        wr_before = wr_count;
        repeat (7) tick();
        chk("stall_no_writes", 32'(wr_count - wr_before), 32'd0);
        tx_full = 1'b0;
        run_until_halted("stall");
        check_frames("stall_frame");

        // Unknown byte is popped and ignored
        clear_logs();
        send(8'h41);
        tick();
        chk("unknown_popped", 32'(rxq.size()), 32'd0);
        repeat (3) tick();
        chk("unknown_halted", 32'(halt0), 32'd1);
        chk("unknown_no_tx", 32'(log0.size()), 32'd0);
        chk("unknown_no_enable", 32'(pe_count), 32'd0);

        // Reset at frame byte 3 with a breakpoint armed
        send(8'h62); send(8'h12); send(8'h00);
        run_until_halted("rst_bp_load");
        clear_logs();
        send(8'h64);
        wait_log(3, "rst");
        reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (5) tick();
        chk("rst_no_more_writes", 32'(wr_count), 32'd3);
        chk("rst_halted", 32'(halt0), 32'd1);
        pc = 11'h011;
        clear_logs();
        send(8'h63);
        repeat (4) tick();
        send(8'h68);
        run_until_halted("rst_run");
        chk("rst_bp_cleared_enables", 32'(pe_count), 32'd3);
        chk("rst_bp_cleared_pc", 32'(pc), 32'h014);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
